// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR engine: a single 16x16 signed multiplier and one
// accumulator are stepped over TAPS coefficients for every accepted sample.
// The sample history lives in a circular buffer; the coefficients live in a
// register file that can only be written while idle.
//
// Optional feature: define FIR_SAT_EN to saturate out_sample instead of
// truncating (wrapping) acc[30:15].
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   / in_ready / in_sample    sample input handshake (Q1.15)
//   out_valid  / out_ready / out_sample  result output handshake (Q1.15)
//   coef_we, coef_addr, coef_data        coefficient write port (idle only)
//   busy       high while in MAC or OUT
//   dbg_state  current FSM state (IDLE=0, MAC=1, OUT=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid depend on registered state only, and
// out_sample/out_valid stay stable while out_valid is high and out_ready low.
module fir_mac_sequencer #(
  parameter int TAPS  = 16,
  parameter int ACC_W = 40,
  localparam int KW   = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_sample,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_sample,
  input  logic              coef_we,
  input  logic [KW-1:0]     coef_addr,
  input  logic [15:0]       coef_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t state, state_next;
  logic   accept;

  logic signed [15:0]      ring [TAPS];
  logic signed [15:0]      coef [TAPS];
  logic [KW-1:0]           wr_ptr;
  logic [KW-1:0]           n;      // index of the newest sample
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc;

  logic [KW:0]             rd_sum;
  logic [KW-1:0]           rd_idx;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sh;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (k == K_LAST) state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  // (n - k) mod TAPS without relying on TAPS being a power of two
  assign rd_sum   = (k > n) ? ({1'b0, n} + (KW+1)'(TAPS) - {1'b0, k})
                            : ({1'b0, n} - {1'b0, k});
  assign rd_idx   = rd_sum[KW-1:0];
  assign prod     = ring[rd_idx] * coef[k];
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  // Datapath: ring buffer, coefficient file, pointers and accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        ring[i] <= '0;
        coef[i] <= '0;
      end
      wr_ptr <= '0;
      n      <= '0;
      k      <= '0;
      acc    <= '0;
    end else begin
      if (state == IDLE && coef_we && (int'(coef_addr) < TAPS))
        coef[coef_addr] <= coef_data;
      if (accept) begin
        ring[wr_ptr] <= in_sample;
        n            <= wr_ptr;
        wr_ptr       <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
        acc          <= '0;
        k            <= '0;
      end else if (state == MAC) begin
        acc <= acc + prod_ext;
        k   <= (k == K_LAST) ? '0 : k + 1'b1;
      end
    end
  end

  // Output scaling: arithmetic shift by 15, then truncate or saturate
  assign acc_sh = acc >>> 15;

`ifdef FIR_SAT_EN
  always_comb begin
    if (acc_sh > SAT_MAX)      out_sample = 16'h7FFF;
    else if (acc_sh < SAT_MIN) out_sample = 16'h8000;
    else                       out_sample = acc_sh[15:0];
  end
`else
  logic unused_bits;
  assign unused_bits = ^{acc_sh[ACC_W-1:16], SAT_MAX, SAT_MIN};
  assign out_sample  = acc_sh[15:0];
`endif

endmodule
